// File: rtl/ctl_ammo_multi.sv
// Per-player ammunition controller: trigger-edge decrement, timed reload refill,
// and registered BCD digits of each channel's magazine count for the HUD.
module ctl_ammo_multi #(
  parameter int N_PLAYERS     = 2,
  parameter int AMMO_MAX      = 3,
  parameter int RELOAD_CYCLES = 50_000_000,
  parameter int DIGITS        = 2,
  localparam int CTR_W        = $clog2(AMMO_MAX + 1),
  localparam int TMR_W        = $clog2(RELOAD_CYCLES + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            reset_score,
  input  logic [N_PLAYERS-1:0]            shot_fired,
  input  logic [N_PLAYERS-1:0]            reload_req,
  output logic [N_PLAYERS*CTR_W-1:0]      ammo_ctr,
  output logic [N_PLAYERS-1:0]            no_ammo,
  output logic [N_PLAYERS-1:0]            reloading,
  output logic [N_PLAYERS*DIGITS*4-1:0]   bcd
);

  localparam logic [0:0] READY  = 1'b0;
  localparam logic [0:0] RELOAD = 1'b1;

  localparam logic [CTR_W-1:0] AMMO_FULL = CTR_W'(AMMO_MAX);
  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(RELOAD_CYCLES - 1);

  for (genvar g = 0; g < N_PLAYERS; g++) begin : gCh
    logic [CTR_W-1:0]      ammo_q, ammo_d;
    logic [0:0]            state_q, state_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic                  shot_last_q, rld_last_q, no_ammo_q;
    logic [DIGITS*4-1:0]   bcd_q, bcd_d;
    logic                  shot_edge, rld_edge;

    assign shot_edge = shot_fired[g] & ~shot_last_q;
    assign rld_edge  = reload_req[g] & ~rld_last_q;

    // A shot edge takes priority over a reload edge in READY; the dropped reload is not remembered.
    always_comb begin
      ammo_d  = ammo_q;
      state_d = state_q;
      tmr_d   = tmr_q;
      case (state_q)
        READY: begin
          if (shot_edge) begin
            if (ammo_q != '0) ammo_d = ammo_q - CTR_W'(1);
          end else if (rld_edge && (ammo_q != AMMO_FULL)) begin
            state_d = RELOAD;
            tmr_d   = TMR_LOAD;
          end
        end
        default: begin
          if (tmr_q == '0) begin
            ammo_d  = AMMO_FULL;
            state_d = READY;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
      endcase
    end

    always_comb begin
      int unsigned val;
      bcd_d = '0;
      val   = 32'(ammo_q);
      for (int k = 0; k < DIGITS; k++) begin
        bcd_d[k*4 +: 4] = 4'(val % 10);
        val = val / 10;
      end
    end

    // reset_score restores the same state as rst, aborting any reload in flight.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ammo_q      <= AMMO_FULL;
        state_q     <= READY;
        tmr_q       <= '0;
        shot_last_q <= 1'b0;
        rld_last_q  <= 1'b0;
        no_ammo_q   <= 1'b0;
        bcd_q       <= '0;
      end else if (reset_score) begin
        ammo_q      <= AMMO_FULL;
        state_q     <= READY;
        tmr_q       <= '0;
        shot_last_q <= 1'b0;
        rld_last_q  <= 1'b0;
        no_ammo_q   <= 1'b0;
        bcd_q       <= '0;
      end else begin
        ammo_q      <= ammo_d;
        state_q     <= state_d;
        tmr_q       <= tmr_d;
        shot_last_q <= shot_fired[g];
        rld_last_q  <= reload_req[g];
        no_ammo_q   <= (ammo_d == '0);
        bcd_q       <= bcd_d;
      end
    end

    assign ammo_ctr[g*CTR_W +: CTR_W]     = ammo_q;
    assign no_ammo[g]                     = no_ammo_q;
    assign reloading[g]                   = (state_q == RELOAD);
    assign bcd[g*DIGITS*4 +: DIGITS*4]    = bcd_q;
  end

endmodule

// File: tb/tb_ctl_ammo_multi.sv
// Bench for ctl_ammo_multi: per-cycle comparison against a magazine/countdown
// model, plus literal expectations and a second AMMO_MAX=12 build for BCD.
module tb_ctl_ammo_multi;
  localparam int NP = 2;
  localparam int AM = 3;
  localparam int RC = 4;
  localparam int DG = 2;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic resetScore = 1'b0;
  logic [NP-1:0] shotFired = '0;
  logic [NP-1:0] reloadReq = '0;
  logic [NP*CW-1:0] ammoCtr;
  logic [NP-1:0] noAmmo, reloading;
  logic [NP*DG*4-1:0] bcd;

  logic [NP-1:0] shot12 = '0;
  logic [NP*4-1:0] ammo12;
  logic [NP-1:0] noAmmo12, reloading12;
  logic [NP*DG*4-1:0] bcd12;

  int testsRun = 0;
  int failures = 0;
  bit compareEn = 1'b0;

  int mAmmo[NP];
  int mRem[NP];
  bit mPrevShot[NP];
  bit mPrevRld[NP];
  logic [DG*4-1:0] mBcd[NP];

  always #5 clk = ~clk;

  ctl_ammo_multi #(.N_PLAYERS(NP), .AMMO_MAX(AM), .RELOAD_CYCLES(RC), .DIGITS(DG)) dut (
    .clk(clk), .rst(rst), .reset_score(resetScore), .shot_fired(shotFired),
    .reload_req(reloadReq), .ammo_ctr(ammoCtr), .no_ammo(noAmmo),
    .reloading(reloading), .bcd(bcd));

  ctl_ammo_multi #(.N_PLAYERS(NP), .AMMO_MAX(12), .RELOAD_CYCLES(3), .DIGITS(DG)) dut12 (
    .clk(clk), .rst(rst), .reset_score(1'b0), .shot_fired(shot12),
    .reload_req(2'b00), .ammo_ctr(ammo12), .no_ammo(noAmmo12),
    .reloading(reloading12), .bcd(bcd12));

  function automatic logic [DG*4-1:0] toDigits(input int value);
    logic [DG*4-1:0] r;
    int v;
    v = value;
    for (int k = 0; k < DG; k++) begin
      r[k*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: magazine count, cycles of reload left, and the display lagging one edge behind.
  always @(posedge clk or posedge rst) begin
    for (int ch = 0; ch < NP; ch++) begin
      if (rst) begin
        mAmmo[ch] = AM; mRem[ch] = 0; mPrevShot[ch] = 0; mPrevRld[ch] = 0; mBcd[ch] = '0;
      end else begin
        automatic bit se = shotFired[ch] && !mPrevShot[ch];
        automatic bit re = reloadReq[ch] && !mPrevRld[ch];
        automatic logic [DG*4-1:0] shown = toDigits(mAmmo[ch]);
        mPrevShot[ch] = shotFired[ch];
        mPrevRld[ch] = reloadReq[ch];
        if (resetScore) begin
          mAmmo[ch] = AM; mRem[ch] = 0; mPrevShot[ch] = 0; mPrevRld[ch] = 0; shown = '0;
        end else if (mRem[ch] > 0) begin
          mRem[ch]--;
          if (mRem[ch] == 0) mAmmo[ch] = AM;
        end else if (se) begin
          if (mAmmo[ch] > 0) mAmmo[ch]--;
        end else if (re && mAmmo[ch] < AM) begin
          mRem[ch] = RC;
        end
        mBcd[ch] = shown;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (compareEn) begin
      automatic logic [NP*CW-1:0] eAmmo;
      automatic logic [NP-1:0] eEmpty, eRld;
      automatic logic [NP*DG*4-1:0] eBcd;
      for (int ch = 0; ch < NP; ch++) begin
        eAmmo[ch*CW +: CW] = CW'(mAmmo[ch]);
        eEmpty[ch] = (mAmmo[ch] == 0);
        eRld[ch] = (mRem[ch] > 0);
        eBcd[ch*DG*4 +: DG*4] = mBcd[ch];
      end
      checkOutput("cyc_ammo_ctr", 32'(ammoCtr), 32'(eAmmo));
      checkOutput("cyc_no_ammo", 32'(noAmmo), 32'(eEmpty));
      checkOutput("cyc_reloading", 32'(reloading), 32'(eRld));
      checkOutput("cyc_bcd", 32'(bcd), 32'(eBcd));
    end
  end

  task automatic applyStimulus(input logic [NP-1:0] shot, input logic [NP-1:0] rld,
                               input logic rs, input int cycles);
    shotFired = shot;
    reloadReq = rld;
    resetScore = rs;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clk);
    rst = 1'b0;
    compareEn = 1'b1;
    checkOutput("bcd_before_first_edge", 32'(bcd), 32'h0000);
    applyStimulus(2'b00, 2'b00, 1'b0, 1);
    checkOutput("bcd_after_release", 32'(bcd), 32'h0303);
    checkOutput("bcd12_after_release", 32'(bcd12), 32'h1212);

    applyStimulus(2'b01, 2'b00, 1'b0, 1);
    applyStimulus(2'b00, 2'b00, 1'b0, 1);
    checkOutput("ammo_before_async_rst", 32'(ammoCtr), 32'hE);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_ammo", 32'(ammoCtr), 32'hF);
    checkOutput("async_rst_no_ammo", 32'(noAmmo), 32'h0);
    checkOutput("async_rst_reloading", 32'(reloading), 32'h0);
    checkOutput("async_rst_bcd", 32'(bcd), 32'h0000);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(2'b00, 2'b00, 1'b0, 1);
    checkOutput("bcd_after_second_release", 32'(bcd), 32'h0303);

    for (int i = 0; i < 2; i++) begin
      applyStimulus(2'b01, 2'b00, 1'b0, 1);
      applyStimulus(2'b00, 2'b00, 1'b0, 1);
    end
    applyStimulus(2'b01, 2'b00, 1'b0, 1);
    checkOutput("ammo0_empty", 32'(ammoCtr), 32'hC);
    checkOutput("no_ammo_same_edge", 32'(noAmmo), 32'h1);
    checkOutput("bcd_lags_one", 32'(bcd), 32'h0301);
    applyStimulus(2'b00, 2'b00, 1'b0, 1);
    checkOutput("bcd_reaches_zero", 32'(bcd), 32'h0300);
    applyStimulus(2'b01, 2'b00, 1'b0, 1);
    applyStimulus(2'b00, 2'b00, 1'b0, 1);
    checkOutput("no_underflow", 32'(ammoCtr), 32'hC);

    applyStimulus(2'b00, 2'b01, 1'b0, 1);
    checkOutput("reload_entered", 32'(reloading), 32'h1);
    applyStimulus(2'b01, 2'b00, 1'b0, 1);
    applyStimulus(2'b00, 2'b00, 1'b0, 2);
    checkOutput("reload_4th_cycle", 32'(reloading), 32'h1);
    checkOutput("shot_ignored_in_reload", 32'(ammoCtr), 32'hC);
    applyStimulus(2'b00, 2'b00, 1'b0, 1);
    checkOutput("refill_ammo", 32'(ammoCtr), 32'hF);
    checkOutput("refill_no_ammo", 32'(noAmmo), 32'h0);
    checkOutput("refill_reloading", 32'(reloading), 32'h0);

    applyStimulus(2'b00, 2'b01, 1'b0, 1);
    checkOutput("reload_when_full", 32'(reloading), 32'h0);
    applyStimulus(2'b00, 2'b00, 1'b0, 1);
    applyStimulus(2'b01, 2'b00, 1'b0, 10);
    applyStimulus(2'b00, 2'b00, 1'b0, 1);
    checkOutput("held_trigger_once", 32'(ammoCtr), 32'hE);
    applyStimulus(2'b01, 2'b01, 1'b0, 1);
    checkOutput("shot_beats_reload_ammo", 32'(ammoCtr), 32'hD);
    checkOutput("shot_beats_reload_flag", 32'(reloading), 32'h0);
    applyStimulus(2'b00, 2'b00, 1'b0, 2);
    checkOutput("reload_not_queued", 32'(reloading), 32'h0);

    applyStimulus(2'b10, 2'b00, 1'b0, 1);
    applyStimulus(2'b00, 2'b00, 1'b0, 1);
    checkOutput("ch1_shot", 32'(ammoCtr), 32'h9);
    applyStimulus(2'b00, 2'b10, 1'b0, 1);
    checkOutput("ch1_reload_entered", 32'(reloading), 32'h2);
    applyStimulus(2'b00, 2'b00, 1'b0, 1);
    applyStimulus(2'b00, 2'b00, 1'b1, 1);
    checkOutput("abort_reloading", 32'(reloading), 32'h0);
    checkOutput("abort_ammo", 32'(ammoCtr), 32'hF);
    applyStimulus(2'b00, 2'b00, 1'b0, 6);
    checkOutput("no_late_refill", 32'(ammoCtr), 32'hF);
    checkOutput("no_late_reloading", 32'(reloading), 32'h0);

    shot12 = 2'b01;
    applyStimulus(2'b11, 2'b00, 1'b0, 1);
    shot12 = 2'b00;
    checkOutput("both_channels_shoot", 32'(ammoCtr), 32'hA);
    checkOutput("ammo12_after_shot", 32'(ammo12), 32'hCB);
    applyStimulus(2'b00, 2'b00, 1'b0, 1);
    checkOutput("bcd12_eleven", 32'(bcd12), 32'h1211);
    applyStimulus(2'b00, 2'b00, 1'b0, 2);

    compareEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end
endmodule

// File: doc/ctl_ammo_multi.md
Name: ctl_ammo_multi

Overview:
- Parametrised per-player ammunition controller for multi-player Duck Hunt rounds.
- Tracks a magazine counter per channel and decrements it on each rising edge of that channel's trigger.
- Adds a timed reload sequence that refills the magazine, and registered BCD digits for the seven-segment display.
- Sits between the per-player shot detectors and the HUD/display and game-control logic.

Parameters:
- N_PLAYERS, 2, number of independent channels (1..4).
- AMMO_MAX, 3, magazine capacity and refill value (1..99).
- RELOAD_CYCLES, 50_000_000, clk cycles spent in the reload state (>=1).
- DIGITS, 2, BCD digits per channel (must represent AMMO_MAX).
- Derived localparam CTR_W = $clog2(AMMO_MAX+1).
- Derived localparam TMR_W = $clog2(RELOAD_CYCLES+1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- reset_score  in  1  synchronous round restart, all channels.
- shot_fired  in  N_PLAYERS  per-channel trigger level.
- reload_req  in  N_PLAYERS  per-channel reload button level.
- ammo_ctr  out  N_PLAYERS*CTR_W  per-channel count; channel i occupies bits [i*CTR_W +: CTR_W].
- no_ammo  out  N_PLAYERS  per-channel empty flag.
- reloading  out  N_PLAYERS  per-channel reload-in-progress flag.
- bcd  out  N_PLAYERS*DIGITS*4  per-channel BCD, least-significant digit first; channel i occupies [i*DIGITS*4 +: DIGITS*4].

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Values forced by rst (asynchronously) and by reset_score (at the clock edge):
  - ammo_ctr = AMMO_MAX, no_ammo = 0, reloading = 0.
  - bcd = 0, FSM = READY, reload timer = 0.
  - shot and reload edge registers = 0.
- bcd shows the AMMO_MAX digits one clk after reset is released.
- Edge detection: per channel, shot_edge = shot_fired & ~shot_last and rld_edge = reload_req & ~rld_last. Both last registers are updated every cycle.
- Per-channel FSM:
  - READY, on shot_edge with ammo>0: ammo decrements by 1 on the next edge.
  - READY, on shot_edge with ammo==0: no change; no underflow or wrap.
  - READY, on rld_edge with ammo<AMMO_MAX and no shot_edge in the same cycle: go to RELOAD, timer = RELOAD_CYCLES-1.
  - READY, on rld_edge with ammo==AMMO_MAX: ignored.
  - READY, simultaneous shot_edge and rld_edge: the shot wins (decrement) and the reload request is dropped. It is not queued.
  - RELOAD: shot_edge and rld_edge are ignored; the timer decrements each cycle.
  - RELOAD, when timer==0: ammo = AMMO_MAX, go to READY on the same edge.
  - RELOAD lasts exactly RELOAD_CYCLES cycles. reloading = 1 while in RELOAD (registered state decode).
- reset_score during RELOAD aborts the reload immediately: READY, ammo = AMMO_MAX.
- no_ammo is registered from ammo_nxt==0, so it asserts on the same edge the counter reaches 0. It deasserts on the edge the refill lands.
- BCD:
  - Combinational conversion of the registered ammo_ctr into DIGITS decimal digits (digit k = (ammo/10^k) % 10).
  - The digits are then registered, giving 1 cycle latency behind ammo_ctr.
- Channels are fully independent; a given input pattern on channel j never affects channel i≠j.
- No multi-cycle paths; division and modulo are only by constants.

Test Plan:
1. Reset with N_PLAYERS=2, AMMO_MAX=3, RELOAD_CYCLES=4, DIGITS=2:
   - Assert rst mid-cycle -> outputs change immediately: ammo_ctr={3,3}, no_ammo=00, reloading=00.
   - After release, bcd = {0,3,0,3} from the next edge.
2. Three single-cycle pulses on shot_fired[0] -> ammo0 goes 2,1,0.
   - no_ammo[0]=1 on the same edge as ammo0=0; bcd0 digit0=0 one cycle later.
   - A 4th pulse leaves ammo0=0; ammo1 stays 3 throughout.
   - shot_fired[0] held high for 10 cycles -> exactly one decrement.
3. From ammo0=0, pulse reload_req[0]:
   - reloading[0]=1 for exactly 4 cycles; shots during that window are ignored.
   - Then ammo0=3, no_ammo[0]=0, reloading[0]=0 on the same edge.
4. Boundary cases on channel 0:
   - reload_req at ammo0=3 -> no RELOAD entry.
   - shot_edge and rld_edge in the same cycle at ammo0=2 -> ammo0=1, reloading stays 0.
5. Abort mid-reload: assert reset_score in reload cycle 2 on channel 1 -> next edge reloading[1]=0, ammo1=3, and no late refill event follows.
6. Both channels shoot in the same cycle -> both decrement independently.
   - Build with AMMO_MAX=12 -> after one shot, bcd = {1,1} for that channel.
